// File: rtl/serial_to_parallel_loader.sv
// Serial-to-parallel deserializer with a double-buffered valid/ready parallel output.
// Define SERIAL_TO_PARALLEL_LOADER_PARITY_EN to append and check an even-parity bit per frame.
module serial_to_parallel_loader #(
    parameter int unsigned N         = 4,
    parameter int unsigned MSB_FIRST = 0,
    localparam int unsigned CW       = $clog2(N + 2)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          clear_n,
    input  logic          ser_in,
    input  logic          ser_valid,
    output logic          ser_ready,
    output logic [N-1:0]  par_out,
    output logic          par_valid,
    input  logic          par_ready,
    output logic [CW-1:0] bit_count,
    output logic          parity_err
);

`ifdef SERIAL_TO_PARALLEL_LOADER_PARITY_EN
    localparam int unsigned PB = 1;
`else
    localparam int unsigned PB = 0;
`endif
    localparam int unsigned L   = N + PB;
    // MSB-first frames end with the parity bit in bit 0, so the data sits one place up
    localparam int unsigned DLO = (MSB_FIRST != 0) ? PB : 0;

    logic [L-1:0]  sr_q, sr_d, sr_shift;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  par_q, par_d;
    logic          pv_q, pv_d;
    logic          perr_d;
    logic          last_bit, accept, consume, word_ok;

    assign last_bit  = (cnt_q == CW'(L - 1));
    assign ser_ready = !(last_bit && pv_q && !par_ready);
    assign accept    = ser_valid && ser_ready;
    assign consume   = pv_q && par_ready;

    always_comb begin
        if (MSB_FIRST != 0) sr_shift = {sr_q[L-2:0], ser_in};
        else                sr_shift = {ser_in, sr_q[L-1:1]};
    end

`ifdef SERIAL_TO_PARALLEL_LOADER_PARITY_EN
    assign word_ok = ~^sr_shift;
`else
    assign word_ok = 1'b1;
`endif

    // Next-state: acceptance, completion and consumption; clear overrides all
    always_comb begin
        sr_d   = sr_q;
        cnt_d  = cnt_q;
        par_d  = par_q;
        pv_d   = pv_q;
        perr_d = 1'b0;
        if (consume) pv_d = 1'b0;
        if (accept) begin
            sr_d = sr_shift;
            if (last_bit) begin
                cnt_d = '0;
                if (word_ok) begin
                    par_d = sr_shift[DLO +: N];
                    pv_d  = 1'b1;
                end else begin
                    perr_d = 1'b1;
                end
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
        if (!clear_n) begin
            sr_d   = '0;
            cnt_d  = '0;
            par_d  = '0;
            pv_d   = 1'b0;
            perr_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sr_q  <= '0;
            cnt_q <= '0;
            par_q <= '0;
            pv_q  <= 1'b0;
        end else begin
            sr_q  <= sr_d;
            cnt_q <= cnt_d;
            par_q <= par_d;
            pv_q  <= pv_d;
        end
    end

`ifdef SERIAL_TO_PARALLEL_LOADER_PARITY_EN
    logic perr_q;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) perr_q <= 1'b0;
        else          perr_q <= perr_d;
    end
    assign parity_err = perr_q;
`else
    logic unused_perr;
    assign unused_perr = perr_d;
    assign parity_err  = 1'b0;
`endif

    assign par_out   = par_q;
    assign par_valid = pv_q;
    assign bit_count = cnt_q;

endmodule
